// File: rtl/avalon_xbar_arbiter_pkg.sv
// Shared interconnect definitions: sizes, select encoding, slot states, command payload.
package avalon_xbar_arbiter_pkg;

  localparam int unsigned NUM_INPUTS  = 5;
  localparam int unsigned NUM_OUTPUTS = 5;
  localparam int unsigned ADDR_W      = 30;
  localparam int unsigned BURST_W     = 8;
  localparam int unsigned SEL_W       = $clog2(NUM_INPUTS + 1);
  localparam int unsigned SEL_NONE    = NUM_INPUTS;

  typedef enum logic {
    SLOT_IDLE  = 1'b0,
    SLOT_OWNED = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               rd;
    logic               wr;
    logic [BURST_W-1:0] burst;
  } avl_cmd_t;

  // Round-robin successor of a master index, wrapping at n.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx, input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? SEL_W'(0) : (idx + SEL_W'(1));
  endfunction

endpackage

// File: rtl/avalon_xbar_arbiter_if.sv
// Master command / slave stall bundle between the masters, slaves and the arbiter.
interface avalon_xbar_arbiter_if #(
  parameter int unsigned N_IN  = avalon_xbar_arbiter_pkg::NUM_INPUTS,
  parameter int unsigned N_OUT = avalon_xbar_arbiter_pkg::NUM_OUTPUTS
);
  import avalon_xbar_arbiter_pkg::*;

  logic [ADDR_W*N_IN-1:0]  i_AVIn_Addr;
  logic [N_IN-1:0]         i_AVIn_Read;
  logic [N_IN-1:0]         i_AVIn_Write;
  logic [BURST_W*N_IN-1:0] i_AVIn_BurstCount;
  logic [N_OUT-1:0]        i_AVOut_WaitRequest;
  logic [SEL_W*N_OUT-1:0]  o_MuxSel;
  logic [N_IN-1:0]         o_AVIn_Stall;
  logic [N_IN-1:0]         o_DecodeErr;

  modport slave (
    input  i_AVIn_Addr, i_AVIn_Read, i_AVIn_Write, i_AVIn_BurstCount, i_AVOut_WaitRequest,
    output o_MuxSel, o_AVIn_Stall, o_DecodeErr
  );

  modport master (
    output i_AVIn_Addr, i_AVIn_Read, i_AVIn_Write, i_AVIn_BurstCount, i_AVOut_WaitRequest,
    input  o_MuxSel, o_AVIn_Stall, o_DecodeErr
  );

endinterface

// File: rtl/avalon_rr_slot.sv
// One slave's round-robin ownership slot: grants a master for a whole burst.
module avalon_rr_slot #(
  parameter int unsigned N_IN = avalon_xbar_arbiter_pkg::NUM_INPUTS
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [N_IN-1:0]                              req,
  input  logic [N_IN-1:0]                              active,
  input  logic [avalon_xbar_arbiter_pkg::BURST_W*N_IN-1:0] burst,
  input  logic                                         wait_req,
  output logic [avalon_xbar_arbiter_pkg::SEL_W-1:0]    sel,
  output logic                                         owned,
  output logic [avalon_xbar_arbiter_pkg::SEL_W-1:0]    owner
);
  import avalon_xbar_arbiter_pkg::*;

  slot_state_e        state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  logic               found_c;
  logic [SEL_W-1:0]   pick_c;
  logic [BURST_W-1:0] pick_burst_c;
  logic               owner_act_c;
  logic               beat_c;

  // Pick first requester at/after the pointer, then wrap to the lower indices.
  always_comb begin
    found_c      = 1'b0;
    pick_c       = '0;
    pick_burst_c = '0;
    owner_act_c  = 1'b0;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (!found_c && req[k] && (32'(k) >= 32'(ptr_q))) begin
        found_c      = 1'b1;
        pick_c       = SEL_W'(k);
        pick_burst_c = burst[k*BURST_W +: BURST_W];
      end
    end
    for (int k = 0; k < int'(N_IN); k++) begin
      if (!found_c && req[k]) begin
        found_c      = 1'b1;
        pick_c       = SEL_W'(k);
        pick_burst_c = burst[k*BURST_W +: BURST_W];
      end
    end
    for (int k = 0; k < int'(N_IN); k++) begin
      if (owner_q == SEL_W'(k)) owner_act_c = active[k];
    end
  end

  assign beat_c = owner_act_c && !wait_req;

  // Next-state: grant from IDLE, count beats in OWNED, release on the last one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      SLOT_IDLE: begin
        if (found_c) begin
          state_d = SLOT_OWNED;
          owner_d = pick_c;
          sel_d   = pick_c;
          cnt_d   = (pick_burst_c == '0) ? BURST_W'(1) : pick_burst_c;
          ptr_d   = rr_next(pick_c, N_IN);
        end
      end
      SLOT_OWNED: begin
        if (beat_c) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) begin
            state_d = SLOT_IDLE;
            sel_d   = SEL_W'(SEL_NONE);
          end
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  // Slot state register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      sel_q   <= SEL_W'(SEL_NONE);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel   = sel_q;
  assign owned = (state_q == SLOT_OWNED);
  assign owner = owner_q;

endmodule

// File: rtl/avalon_xbar_arbiter.sv
// Crossbar arbiter: address decode, one round-robin slot per slave, master stall/error.
module avalon_xbar_arbiter #(
  parameter int unsigned               NUM_INPUTS  = avalon_xbar_arbiter_pkg::NUM_INPUTS,
  parameter int unsigned               NUM_OUTPUTS = avalon_xbar_arbiter_pkg::NUM_OUTPUTS,
  parameter logic [30*NUM_OUTPUTS-1:0] SLAVE_BASE  = '0,
  parameter logic [30*NUM_OUTPUTS-1:0] SLAVE_MASK  = '0
) (
  input logic                  i_Clk,
  input logic                  i_Rst_n,
  avalon_xbar_arbiter_if.slave bus
);
  import avalon_xbar_arbiter_pkg::*;

  avl_cmd_t                                cmd_c [NUM_INPUTS];
  logic [BURST_W*NUM_INPUTS-1:0]           burst_c;
  logic [NUM_INPUTS-1:0]                   active_c;
  logic [NUM_INPUTS-1:0]                   hit_c;
  logic [NUM_INPUTS-1:0]                   miss_c;
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0]  slot_req_c;
  logic [NUM_INPUTS-1:0]                   stall_c;
  logic [NUM_OUTPUTS-1:0]                  owned_c;
  logic [SEL_W-1:0]                        owner_c [NUM_OUTPUTS];
  logic [SEL_W*NUM_OUTPUTS-1:0]            mux_sel;
  logic [NUM_INPUTS-1:0]                   decode_err_q, decode_err_d;

  // Unpack flat master buses into per-master commands.
  always_comb begin
    burst_c = '0;
    for (int m = 0; m < int'(NUM_INPUTS); m++) begin
      cmd_c[m].addr  = bus.i_AVIn_Addr[m*ADDR_W +: ADDR_W];
      cmd_c[m].rd    = bus.i_AVIn_Read[m];
      cmd_c[m].wr    = bus.i_AVIn_Write[m];
      cmd_c[m].burst = bus.i_AVIn_BurstCount[m*BURST_W +: BURST_W];
      burst_c[m*BURST_W +: BURST_W] = cmd_c[m].burst;
    end
  end

  // Address decode; lowest matching slave wins on overlapping windows.
  always_comb begin
    active_c   = '0;
    hit_c      = '0;
    miss_c     = '0;
    slot_req_c = '0;
    for (int m = 0; m < int'(NUM_INPUTS); m++) begin
      active_c[m] = cmd_c[m].rd | cmd_c[m].wr;
      for (int s = 0; s < int'(NUM_OUTPUTS); s++) begin
        if (active_c[m] && !hit_c[m] &&
            ((cmd_c[m].addr & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_BASE[s*ADDR_W +: ADDR_W])) begin
          slot_req_c[s][m] = 1'b1;
          hit_c[m]         = 1'b1;
        end
      end
      miss_c[m] = active_c[m] && !hit_c[m];
    end
  end

  for (genvar s = 0; s < int'(NUM_OUTPUTS); s++) begin : g_slot
    avalon_rr_slot #(.N_IN(NUM_INPUTS)) u_slot (
      .clk      (i_Clk),
      .rst_n    (i_Rst_n),
      .req      (slot_req_c[s]),
      .active   (active_c),
      .burst    (burst_c),
      .wait_req (bus.i_AVOut_WaitRequest[s]),
      .sel      (mux_sel[s*SEL_W +: SEL_W]),
      .owned    (owned_c[s]),
      .owner    (owner_c[s])
    );
  end

  // Stall any requester that is not the current owner of its target slave.
  always_comb begin
    stall_c = '0;
    for (int s = 0; s < int'(NUM_OUTPUTS); s++) begin
      for (int m = 0; m < int'(NUM_INPUTS); m++) begin
        if (slot_req_c[s][m] && !(owned_c[s] && (owner_c[s] == SEL_W'(m)))) stall_c[m] = 1'b1;
      end
    end
    if (!i_Rst_n) stall_c = '0;
  end

  assign decode_err_d = miss_c;

  // Decode miss pulse, one cycle after the offending access.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) decode_err_q <= '0;
    else          decode_err_q <= decode_err_d;
  end

  assign bus.o_MuxSel     = mux_sel;
  assign bus.o_AVIn_Stall = stall_c;
  assign bus.o_DecodeErr  = decode_err_q;

endmodule

// File: tb/tb_avalon_xbar_arbiter.sv
// Scoreboard bench: directed scenarios plus random traffic against a burst-ownership model.
module tb_avalon_xbar_arbiter;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam logic [149:0] BASE = {30'h00400000, 30'h00300000, 30'h00200000, 30'h00100000, 30'h00000000};
  localparam logic [149:0] MASK = {5{30'h3FF00000}};
  localparam logic [14:0]  ALL_NONE = {5{3'd5}};

  logic i_Clk;
  logic i_Rst_n;

  avalon_xbar_arbiter_if #(.N_IN(NI), .N_OUT(NO)) bus ();

  avalon_xbar_arbiter #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .bus    (bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Staged stimulus, applied just after each rising edge.
  logic [29:0] s_addr [NI];
  logic        s_rd   [NI];
  logic        s_wr   [NI];
  logic [7:0]  s_bc   [NI];
  logic        s_wait [NO];
  logic        s_rst;

  // Reference model: who owns each slave, beats left, next preferred master.
  int m_owner [NO];
  int m_left  [NO];
  int m_pref  [NO];
  bit m_err   [NI];

  typedef struct {
    logic [14:0] mux;
    logic [4:0]  stall;
    logic [4:0]  err;
  } exp_t;
  exp_t exp_q[$];

  int n_chk;
  int n_fail;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic bit is_active(int m);
    return bus.i_AVIn_Read[m] || bus.i_AVIn_Write[m];
  endfunction

  // Slave s owns word addresses whose upper ten bits equal s.
  function automatic int target_of(int m);
    int region;
    if (!is_active(m)) return -1;
    region = int'(bus.i_AVIn_Addr[m*30+20 +: 10]);
    return (region < NO) ? region : -1;
  endfunction

  function automatic int mux_of(int s);
    return int'(bus.o_MuxSel[s*3 +: 3]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NO; s++) begin
      m_owner[s] = -1;
      m_left[s]  = 0;
      m_pref[s]  = 0;
    end
    for (int m = 0; m < NI; m++) m_err[m] = 1'b0;
  endtask

  // Effect of one rising edge given the inputs held during the cycle before it.
  task automatic model_edge();
    int tgt [NI];
    int c;
    bit done;
    for (int m = 0; m < NI; m++) tgt[m] = target_of(m);
    for (int s = 0; s < NO; s++) begin
      if (m_owner[s] >= 0) begin
        if (is_active(m_owner[s]) && !bus.i_AVOut_WaitRequest[s]) begin
          m_left[s] = m_left[s] - 1;
          if (m_left[s] == 0) m_owner[s] = -1;
        end
      end else begin
        done = 1'b0;
        for (int k = 0; k < NI; k++) begin
          c = (m_pref[s] + k) % NI;
          if (!done && tgt[c] == s) begin
            done       = 1'b1;
            m_owner[s] = c;
            m_left[s]  = (bus.i_AVIn_BurstCount[c*8 +: 8] == 8'd0) ? 1 : int'(bus.i_AVIn_BurstCount[c*8 +: 8]);
            m_pref[s]  = (c + 1) % NI;
          end
        end
      end
    end
    for (int m = 0; m < NI; m++) m_err[m] = is_active(m) && (tgt[m] < 0);
  endtask

  task automatic apply();
    i_Rst_n = s_rst;
    for (int m = 0; m < NI; m++) begin
      bus.i_AVIn_Addr[m*30 +: 30]      = s_addr[m];
      bus.i_AVIn_Read[m]               = s_rd[m];
      bus.i_AVIn_Write[m]              = s_wr[m];
      bus.i_AVIn_BurstCount[m*8 +: 8]  = s_bc[m];
    end
    for (int s = 0; s < NO; s++) bus.i_AVOut_WaitRequest[s] = s_wait[s];
  endtask

  // One cycle: advance the model, apply new stimulus, queue what the DUT must show.
  task automatic tick();
    exp_t e;
    int   t;
    @(posedge i_Clk);
    #1;
    if (i_Rst_n) model_edge();
    else         model_reset();
    apply();
    if (!i_Rst_n) model_reset();
    for (int s = 0; s < NO; s++) e.mux[s*3 +: 3] = (m_owner[s] < 0) ? 3'd5 : 3'(m_owner[s]);
    for (int m = 0; m < NI; m++) begin
      t = target_of(m);
      e.stall[m] = i_Rst_n && (t >= 0) && (m_owner[t] != m);
      e.err[m]   = m_err[m];
    end
    exp_q.push_back(e);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clr_all();
    for (int m = 0; m < NI; m++) begin
      s_addr[m] = '0;
      s_rd[m]   = 1'b0;
      s_wr[m]   = 1'b0;
      s_bc[m]   = '0;
    end
    for (int s = 0; s < NO; s++) s_wait[s] = 1'b0;
  endtask

  task automatic req(int m, bit wr, int slave, int bc);
    s_addr[m] = 30'(slave << 20);
    s_rd[m]   = !wr;
    s_wr[m]   = wr;
    s_bc[m]   = 8'(bc);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_muxsel", 32'(bus.o_MuxSel), 32'(e.mux));
        chk("sb_stall", 32'(bus.o_AVIn_Stall), 32'(e.stall));
        chk("sb_decerr", 32'(bus.o_DecodeErr), 32'(e.err));
      end
    end
  end

  initial begin
    int waits [6];
    int slave;
    n_chk  = 0;
    n_fail = 0;
    waits  = '{0, 1, 0, 1, 0, 0};
    clr_all();
    s_rst = 1'b0;
    apply();
    model_reset();

    repeat (2) tick();
    settle();
    chk("reset_muxsel", 32'(bus.o_MuxSel), 32'(ALL_NONE));
    chk("reset_stall", 32'(bus.o_AVIn_Stall), 32'd0);
    chk("reset_decerr", 32'(bus.o_DecodeErr), 32'd0);
    s_rst = 1'b1;
    tick();

    // Single write M2 -> S1.
    req(2, 1'b1, 1, 1);
    tick(); settle();
    chk("wr_stall_c0", 32'(bus.o_AVIn_Stall[2]), 32'd1);
    chk("wr_mux_c0", 32'(mux_of(1)), 32'd5);
    tick(); settle();
    chk("wr_mux_c1", 32'(mux_of(1)), 32'd2);
    chk("wr_stall_c1", 32'(bus.o_AVIn_Stall[2]), 32'd0);
    s_wr[2] = 1'b0;
    tick(); settle();
    chk("wr_mux_c2", 32'(mux_of(1)), 32'd5);

    // Contention M0 vs M3 on S0.
    req(0, 1'b0, 0, 1);
    req(3, 1'b0, 0, 1);
    tick(); settle();
    chk("cont_stall0", 32'(bus.o_AVIn_Stall[0]), 32'd1);
    chk("cont_stall3", 32'(bus.o_AVIn_Stall[3]), 32'd1);
    tick(); settle();
    chk("cont_grant0", 32'(mux_of(0)), 32'd0);
    chk("cont_m3_wait", 32'(bus.o_AVIn_Stall[3]), 32'd1);
    s_rd[0] = 1'b0;
    tick(); settle();
    chk("cont_bubble", 32'(mux_of(0)), 32'd5);
    tick(); settle();
    chk("cont_grant3", 32'(mux_of(0)), 32'd3);
    chk("cont_m3_go", 32'(bus.o_AVIn_Stall[3]), 32'd0);
    s_rd[3] = 1'b0;
    tick();

    // Pointer now 4: M1 and M4 compete, M4 wins, then M1.
    req(1, 1'b0, 0, 1);
    req(4, 1'b0, 0, 1);
    tick();
    tick(); settle();
    chk("wrap_grant4", 32'(mux_of(0)), 32'd4);
    s_rd[4] = 1'b0;
    tick();
    tick(); settle();
    chk("wrap_grant1", 32'(mux_of(0)), 32'd1);
    s_rd[1] = 1'b0;
    tick();

    // Burst of 4 to S2 with two wait cycles: six owned cycles.
    req(1, 1'b0, 2, 4);
    tick(); settle();
    chk("burst_grant_stall", 32'(bus.o_AVIn_Stall[1]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      s_wait[2] = waits[k][0];
      tick(); settle();
      chk("burst_owned", 32'(mux_of(2)), 32'd1);
    end
    s_rd[1]   = 1'b0;
    s_wait[2] = 1'b0;
    tick(); settle();
    chk("burst_released", 32'(mux_of(2)), 32'd5);

    // Decode miss.
    req(0, 1'b0, 7, 1);
    tick(); settle();
    chk("miss_stall", 32'(bus.o_AVIn_Stall[0]), 32'd0);
    chk("miss_err_c0", 32'(bus.o_DecodeErr[0]), 32'd0);
    s_rd[0] = 1'b0;
    tick(); settle();
    chk("miss_err_c1", 32'(bus.o_DecodeErr[0]), 32'd1);
    chk("miss_mux", 32'(bus.o_MuxSel), 32'(ALL_NONE));
    tick(); settle();
    chk("miss_err_c2", 32'(bus.o_DecodeErr[0]), 32'd0);

    // Reset in the middle of a burst.
    req(3, 1'b1, 4, 4);
    tick();
    tick(); settle();
    chk("rst_owned", 32'(mux_of(4)), 32'd3);
    tick();
    s_rst = 1'b0;
    tick(); settle();
    chk("rst_mux", 32'(bus.o_MuxSel), 32'(ALL_NONE));
    chk("rst_stall", 32'(bus.o_AVIn_Stall), 32'd0);
    s_rst = 1'b1;
    tick(); settle();
    chk("rst_release_stall", 32'(bus.o_AVIn_Stall[3]), 32'd1);
    tick(); settle();
    chk("rst_regrant", 32'(mux_of(4)), 32'd3);

    // Random traffic with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < NI; m++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) < 6) begin
            slave     = int'($urandom_range(0, 6));
            s_addr[m] = 30'(slave << 20) | 30'($urandom_range(0, 20'hFFFFF));
            s_wr[m]   = $urandom_range(0, 1) == 1;
            s_rd[m]   = !s_wr[m];
            s_bc[m]   = 8'($urandom_range(0, 5));
          end else begin
            s_rd[m] = 1'b0;
            s_wr[m] = 1'b0;
          end
        end
      end
      for (int s = 0; s < NO; s++) s_wait[s] = ($urandom_range(0, 3) == 0);
      s_rst = ($urandom_range(0, 599) != 0);
      tick();
    end

    clr_all();
    s_rst = 1'b1;
    tick();
    tick();
    @(negedge i_Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_xbar_arbiter.md
AVALON_XBAR_ARBITER -- requirements
Module: avalon_xbar_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5: number of masters.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 5: number of slaves.
REQ-003 SHALL have parameter SLAVE_BASE, width 30*NUM_OUTPUTS, default 0: per-slave word-address base, slice 30*s.
REQ-004 SHALL have parameter SLAVE_MASK, width 30*NUM_OUTPUTS, default 0: per-slave decode mask, slice 30*s.
REQ-005 SHALL have port i_Clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_AVIn_Addr, input, width 30*NUM_INPUTS: master word addresses.
REQ-008 SHALL have ports i_AVIn_Read and i_AVIn_Write, input, width NUM_INPUTS each: master commands.
REQ-009 SHALL have port i_AVIn_BurstCount, input, width 8*NUM_INPUTS: master burst lengths.
REQ-010 SHALL have port i_AVOut_WaitRequest, input, width NUM_OUTPUTS: slave stalls.
REQ-011 SHALL have port o_MuxSel, output, width 3*NUM_OUTPUTS: registered select for each crossbar output; value NUM_INPUTS (5) = no owner.
REQ-012 SHALL have port o_AVIn_Stall, output, width NUM_INPUTS: per-master stall, ORed into the master waitrequest by the integrator.
REQ-013 SHALL have port o_DecodeErr, output, width NUM_INPUTS: registered one-cycle pulse on an address miss.

Function
REQ-014 SHALL decode each master as request to slave s when (read|write) and (addr & MASK_s) == BASE_s; on overlap, the lowest s wins.
REQ-015 SHALL run one arbitration slot per slave, with states IDLE and OWNED, a 3-bit owner, an 8-bit beat counter and a 3-bit round-robin pointer.
REQ-016 SHALL, in IDLE with at least one requester, select the first requester at or after the pointer (wrapping modulo NUM_INPUTS), then go to OWNED, set owner and o_MuxSel slice, load the counter with that master's burstcount (0 treated as 1), and set pointer = owner+1 mod NUM_INPUTS.
REQ-017 SHALL treat a beat as: owner's read or write high and slave waitrequest low, in OWNED; each beat decrements the counter.
REQ-018 SHALL, on the beat with counter==1, return the slot to IDLE with o_MuxSel = NUM_INPUTS at the next edge; re-arbitration happens in the following IDLE cycle (one bubble).
REQ-019 SHALL hold ownership while the owner deasserts read/write mid-burst; there is no timeout.
REQ-020 SHALL drive o_AVIn_Stall[m] combinationally high when m requests slave s and is not the current OWNED owner of s; this covers the grant cycle (one-cycle arbitration latency).
REQ-021 SHALL pulse o_DecodeErr[m] one cycle after a cycle in which m issues read/write with no slave hit; stall stays low for that master, and the crossbar terminates the access with zero data.
REQ-022 SHALL allow different slaves to grant different masters in the same cycle; a master holds at most one slot, since it presents one address.

Reset
REQ-023 SHALL, while i_Rst_n is low, immediately force every slot to IDLE, owner 0, counter 0, pointer 0, all o_MuxSel slices to NUM_INPUTS, o_DecodeErr to 0, and hence o_AVIn_Stall to 0.
REQ-024 SHALL, when reset is asserted mid-burst, abandon the burst; after release, arbitration restarts from pointer 0.

Structure
REQ-025 SHALL take NUM_INPUTS, NUM_OUTPUTS, SEL_W (= clog2(NUM_INPUTS+1)), SEL_NONE (= NUM_INPUTS) and the IDLE/OWNED state encoding from the shared interconnect package.
REQ-026 SHALL implement one slot as sub-module avalon_rr_slot, instantiated NUM_OUTPUTS times, with decode and stall/error logic at top level.

Verification
REQ-027 SHALL cover single write: M2 writes to S1 region, burst 1, slave wait 0 -> stall high cycle 0, MuxSel[5:3]=2 at cycle 1, beat cycle 1, MuxSel[5:3]=5 at cycle 2.
REQ-028 SHALL cover contention: M0 and M3 read S0 together, pointer 0 -> M0 granted, M3 stalled; after M0 finishes, M3 granted and pointer=4.
REQ-029 SHALL cover a burst with waits: M1 burst 4 to S2, waitrequest high on 2 cycles -> ownership held exactly 6 OWNED cycles, then released.
REQ-030 SHALL cover wrap: pointer 4, requesters M1 and M4 -> M4 granted, pointer wraps to 0; next grant goes to M1.
REQ-031 SHALL cover decode miss: M0 read at an unmapped address -> o_DecodeErr[0] pulses one cycle later, stall 0, no MuxSel change.
REQ-032 SHALL cover reset mid-burst: reset at beat 2 of 4 -> all MuxSel = 5 immediately, stall 0; after release, a fresh request is granted normally.
